// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: in-order write-back stage versus buffered
// out-of-order multi-cycle results, with starvation forcing and stale-result squash.
module wb_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        MulValid,
    input  logic [4:0]  MulReg,
    input  logic [31:0] MulData,
    output logic        MulReady,
    output logic        StallW,
    output logic        RegWriteR,
    output logic [4:0]  WriteRegR,
    output logic [31:0] WriteDataR
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    head_reg, head_next;
    logic [AW-1:0]    tail_reg, tail_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [3:0]       sc_reg, sc_next;
    logic [DEPTH-1:0] ent_valid_reg, ent_valid_next;
    logic [4:0]       ent_rd_reg   [DEPTH];
    logic [31:0]      ent_data_reg [DEPTH];

    logic full, head_valid, pend, pw, force_drain;
    logic grant_mul, grant_pipe, push, pop;

    assign full        = (count_reg == CW'(DEPTH));
    assign MulReady    = !full;
    assign head_valid  = ent_valid_reg[head_reg];
    assign pend        = (count_reg != '0) && head_valid;
    assign pw          = RegWriteW && (WriteRegW != 5'd0);
    assign force_drain = pend && (sc_reg == 4'(STARVE_LIMIT));
    assign grant_mul   = force_drain || (pend && !pw);
    assign grant_pipe  = pw && !force_drain;
    assign StallW      = force_drain && pw;
    // A squashed head is retired without touching the write port.
    assign pop         = (count_reg != '0) && (grant_mul || !head_valid);
    assign push        = MulValid && !full && (MulReg != 5'd0);

    always_comb begin
        RegWriteR  = 1'b0;
        WriteRegR  = 5'd0;
        WriteDataR = 32'd0;
        if (grant_mul) begin
            RegWriteR  = 1'b1;
            WriteRegR  = ent_rd_reg[head_reg];
            WriteDataR = ent_data_reg[head_reg];
        end else if (grant_pipe) begin
            RegWriteR  = 1'b1;
            WriteRegR  = WriteRegW;
            WriteDataR = ResultW;
        end
    end

    always_comb begin
        sc_next = sc_reg;
        if (!pend || grant_mul) begin
            sc_next = 4'd0;
        end else if (sc_reg < 4'(STARVE_LIMIT)) begin
            sc_next = sc_reg + 4'd1;
        end
    end

    always_comb begin
        head_next  = pop  ? head_reg + AW'(1) : head_reg;
        tail_next  = push ? tail_reg + AW'(1) : tail_reg;
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Push and pop never target the same slot: push needs !full, pop needs count!=0,
    // and head==tail only when the buffer is empty or full.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic squash_hit;
            assign squash_hit = grant_pipe && ent_valid_reg[gi] && (ent_rd_reg[gi] == WriteRegW);
            assign ent_valid_next[gi] =
                (push && (tail_reg == AW'(gi))) ? 1'b1 :
                (pop  && (head_reg == AW'(gi))) ? 1'b0 :
                squash_hit                      ? 1'b0 :
                                                  ent_valid_reg[gi];
        end
    endgenerate

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            sc_reg        <= 4'd0;
            ent_valid_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_reg[i]   <= 5'd0;
                ent_data_reg[i] <= 32'd0;
            end
        end else begin
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            count_reg     <= count_next;
            sc_reg        <= sc_next;
            ent_valid_reg <= ent_valid_next;
            if (push) begin
                ent_rd_reg[tail_reg]   <= MulReg;
                ent_data_reg[tail_reg] <= MulData;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed bench for wb_write_arbiter against a queue-based model
// of the arbitration rules.
module tb_wb_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        MulValid;
    logic [4:0]  MulReg;
    logic [31:0] MulData;
    logic        MulReady;
    logic        StallW;
    logic        RegWriteR;
    logic [4:0]  WriteRegR;
    logic [31:0] WriteDataR;

    wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .Clock(Clock), .Reset(Reset),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .MulValid(MulValid), .MulReg(MulReg), .MulData(MulData),
        .MulReady(MulReady), .StallW(StallW),
        .RegWriteR(RegWriteR), .WriteRegR(WriteRegR), .WriteDataR(WriteDataR)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit        valid;
        bit [4:0]  rd;
        bit [31:0] data;
    } ent_t;

    ent_t q[$];
    int   sc;
    int   checks;
    int   errors;
    bit   exp_stall;
    bit   exp_accept;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare combinational outputs, advance the model.
    task automatic step(input bit rw, input bit [4:0] wr, input bit [31:0] res,
                        input bit mv, input bit [4:0] mr, input bit [31:0] md);
        bit pend, frc, pw, gmul, gpipe, ready, do_pop;
        bit [4:0]  e_reg;
        bit [31:0] e_data;
        @(negedge Clock);
        RegWriteW = rw; WriteRegW = wr; ResultW = res;
        MulValid  = mv; MulReg    = mr; MulData = md;
        #1;
        pend  = (q.size() != 0) && q[0].valid;
        frc   = pend && (sc == LIMIT);
        pw    = rw && (wr != 0);
        gmul  = frc || (pend && !pw);
        gpipe = pw && !frc;
        ready = (q.size() < DEPTH);
        exp_stall  = frc && pw;
        exp_accept = mv && ready;
        e_reg  = gmul ? q[0].rd   : (gpipe ? wr  : 5'd0);
        e_data = gmul ? q[0].data : (gpipe ? res : 32'd0);
        chk("we",    RegWriteR,  32'(gmul || gpipe));
        chk("wreg",  WriteRegR,  32'(e_reg));
        chk("wdata", WriteDataR, e_data);
        chk("stall", StallW,     32'(exp_stall));
        chk("ready", MulReady,   32'(ready));
        $display("t=%0t w=%0b/%0d mul=%0b/%0d -> we=%0b r%0d=%08h stall=%0b rdy=%0b",
                 $time, rw, wr, mv, mr, RegWriteR, WriteRegR, WriteDataR, StallW, MulReady);
        do_pop = (q.size() != 0) && (gmul || !q[0].valid);
        if (gpipe) begin
            foreach (q[i]) if (q[i].valid && q[i].rd == wr) q[i].valid = 1'b0;
        end
        if (!pend || gmul) sc = 0;
        else if (sc < LIMIT) sc++;
        if (do_pop) void'(q.pop_front());
        if (mv && ready && mr != 0) q.push_back('{valid: 1'b1, rd: mr, data: md});
    endtask

    task automatic idle_until_empty();
        for (int i = 0; i < 20 && q.size() != 0; i++) step(0, 0, 0, 0, 0, 0);
        chk("drain_bound", 32'(q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},    RegWriteR,  0);
        chk({tag, "_wreg"},  WriteRegR,  0);
        chk({tag, "_wdata"}, WriteDataR, 0);
        chk({tag, "_stall"}, StallW,     0);
        chk({tag, "_ready"}, MulReady,   1);
    endtask

    initial begin
        bit        hrw;
        bit [4:0]  hwr;
        bit [31:0] hres;
        checks = 0; errors = 0; sc = 0;
        Reset = 1'b1;
        RegWriteW = 0; WriteRegW = 0; ResultW = 0;
        MulValid = 0; MulReg = 0; MulData = 0;
        repeat (2) @(posedge Clock);
        #1;
        check_reset_outputs("rst");
        @(negedge Clock);
        Reset = 1'b0;

        // Single result, one-cycle latency, then empty.
        step(0, 0, 0, 1, 5, 32'h1234);
        chk("tp1_noBypass", RegWriteR, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("tp1_reg",  WriteRegR,  5);
        chk("tp1_data", WriteDataR, 32'h1234);
        step(0, 0, 0, 0, 0, 0);
        chk("tp1_empty", RegWriteR, 0);

        // Fill under a continuous pipeline stream; a third result waits for space.
        step(1, 7, 32'h70, 1, 3, 32'h33);
        step(1, 7, 32'h71, 1, 4, 32'h44);
        chk("fill_ready_before", MulReady, 1);
        exp_accept = 0;
        for (int i = 0; i < 20 && !exp_accept; i++) begin
            step(1, 7, 32'h72 + i, 1, 8, 32'h88);
            if (i == 0) chk("fill_ready_full", MulReady, 0);
        end
        chk("fill_accept_bound", 32'(exp_accept), 1);
        idle_until_empty();

        // Starvation: forced drain on the fifth cycle, then the held request.
        step(0, 0, 0, 1, 9, 32'h99);
        for (int i = 0; i < 6; i++) begin
            step(1, 2, 32'h22, 0, 0, 0);
            chk("starve_reg",   WriteRegR, (i == 4) ? 9 : 2);
            chk("starve_stall", StallW,    (i == 4) ? 1 : 0);
        end
        idle_until_empty();

        // Squash: younger pipeline write makes the buffered value stale.
        step(0, 0, 0, 1, 6, 32'hAAAA);
        step(1, 6, 32'hBBBB, 0, 0, 0);
        chk("squash_data", WriteDataR, 32'hBBBB);
        step(0, 0, 0, 0, 0, 0);
        chk("squash_nowrite", RegWriteR, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("squash_nowrite2", RegWriteR, 0);
        chk("squash_empty", 32'(q.size()), 0);

        // Register zero is never written and never enqueued.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
            chk("zero_we",    RegWriteR, 0);
            chk("zero_ready", MulReady,  1);
        end

        // Asynchronous reset with two entries buffered.
        step(1, 7, 32'h1, 1, 3, 32'h3);
        step(1, 7, 32'h2, 1, 4, 32'h4);
        step(1, 7, 32'h3, 0, 0, 0);
        @(negedge Clock);
        RegWriteW = 0; MulValid = 0;
        #2;
        Reset = 1'b1;
        #1;
        check_reset_outputs("amid");
        q.delete(); sc = 0;
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk("postrst_we", RegWriteR, 0);
        end

        // Randomized traffic; W inputs are held through a stall.
        hrw = 0; hwr = 0; hres = 0;
        for (int i = 0; i < 600; i++) begin
            if (!exp_stall) begin
                hrw  = ($urandom_range(0, 3) != 0);
                hwr  = 5'($urandom_range(0, 7));
                hres = $urandom;
            end
            step(hrw, hwr, hres, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end
        idle_until_empty();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
